// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the fifo_wr_arb write-port arbiter.
package fifo_wr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam int MAX_NUM_REQ = 8;
  localparam int IDX_W       = $clog2(MAX_NUM_REQ);

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int n);
    if (int'(ptr) + 1 >= n) return '0;
    return ptr + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);
  localparam logic [IDX_W:0] N = (IDX_W+1)'(NUM_REQ);

  logic [MAX_NUM_REQ-1:0] req_ext;
  logic [IDX_W:0]         sum;
  logic                   found;

  assign req_ext = MAX_NUM_REQ'(req);

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ and k < NUM_REQ, so one subtraction is a full modulo
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= N) sum = sum - N;
      if (!found && req_ext[sum[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win = '0;
    for (int j = 0; j < NUM_REQ; j++) win[j] = found && (win_idx == IDX_W'(j));
  end
endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_WR_ARB_PRIO0_EN to give producer 0 fixed priority over the rotation.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d, rr_win, pick_win;
  logic [IDX_W-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d, rr_idx, pick_idx;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d, cnt_inc;
  logic [MAX_NUM_REQ-1:0] req_ext, last_ext;
  logic [DATA_WIDTH-1:0]  dw [MAX_NUM_REQ];
  logic                   owner_req, exit_burst;

  // Pad producer slices to MAX_NUM_REQ so owner_q indexes exactly
  for (genvar i = 0; i < MAX_NUM_REQ; i++) begin : g_slice
    if (i < NUM_REQ) begin : g_used
      assign dw[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign dw[i] = '0;
    end
  end

  assign req_ext  = MAX_NUM_REQ'(req);
  assign last_ext = MAX_NUM_REQ'(last);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win     (rr_win),
    .win_idx (rr_idx)
  );

`ifdef FIFO_WR_ARB_PRIO0_EN
  assign pick_win = req[0] ? NUM_REQ'(1) : rr_win;
  assign pick_idx = req[0] ? '0 : rr_idx;
`else
  assign pick_win = rr_win;
  assign pick_idx = rr_idx;
`endif

  assign owner_req  = req_ext[owner_q];
  assign busy       = (state_q == BURST);
  assign wr         = busy & owner_req & ~full;
  assign w_data     = busy ? dw[owner_q] : '0;
  assign gnt        = gnt_q;
  assign cnt_inc    = beat_cnt_q + CW'(1);
  assign exit_burst = busy && (!owner_req ||
                      (wr && (last_ext[owner_q] || cnt_inc == CW'(MAX_BURST))));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d    = BURST;
        gnt_d      = pick_win;
        owner_d    = pick_idx;
        beat_cnt_d = '0;
      end
      BURST: begin
        if (wr) beat_cnt_d = cnt_inc;
        if (exit_burst) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (owner_q != '0) rr_ptr_d = rr_next(owner_q, NUM_REQ);
`else
          rr_ptr_d = rr_next(owner_q, NUM_REQ);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized scoreboard bench for fifo_wr_arb against a transaction-level arbiter model.
module tb_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rs_n;
  logic [NR-1:0] req, last, gnt;
  logic [NR*DW-1:0] data;
  logic          full, wr, busy;
  logic [DW-1:0] w_data;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rs_n), .req(req), .last(last), .data(data), .full(full),
    .gnt(gnt), .wr(wr), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          wr;
    logic [DW-1:0] d;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every presented cycle is compared against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("wr", 32'(wr), 32'(e.wr));
      check("busy", 32'(busy), 32'(e.busy));
      check("w_data", 32'(w_data), 32'(e.d));
    end
  end

  // Reference: who owns the port, how many beats it has written, where the rotation resumes
  int            cur = -1, ptr = 0, beats = 0;
  logic [NR-1:0] rq, ls;
  logic [DW-1:0] dat [NR];
  logic          fl, rs;
  int            prev_cur = -1;
  logic          prev_wr = 1'b0;

  task automatic cycle(input int mode);
    exp_t e;
    logic ew;
    bit   acc, found, done;
    int   win;
    @(posedge clk);
    #1;
    // producers: hold a pending word until accepted, otherwise pick fresh activity
    for (int i = 0; i < NR; i++) begin
      acc = prev_wr && (prev_cur == i);
      if (mode == 0) begin
        if (acc) dat[i] = DW'($urandom);
        rq[i] = 1'b1;
        ls[i] = 1'b0;
      end else if (rq[i] && !acc) begin
        if ($urandom_range(0, 19) == 0) rq[i] = 1'b0;
      end else begin
        rq[i]  = $urandom_range(0, 3) != 0;
        ls[i]  = $urandom_range(0, 3) == 0;
        dat[i] = DW'($urandom);
      end
    end
    if (mode == 1) fl = fl ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
    else fl = 1'b0;
    req  = rq;
    last = ls;
    full = fl;
    for (int i = 0; i < NR; i++) data[i*DW +: DW] = dat[i];
    rs_n = rs;
    #1;
    if (!rs) begin
      cur = -1; ptr = 0; beats = 0;
    end
    ew     = (cur >= 0) && rq[cur] && !fl;
    e.gnt  = (cur >= 0) ? NR'(1 << cur) : '0;
    e.wr   = ew;
    e.busy = (cur >= 0);
    e.d    = (cur >= 0) ? dat[cur] : '0;
    exp_q.push_back(e);
    prev_cur = cur;
    prev_wr  = ew;
    if (rs) begin
      if (cur < 0) begin
        found = 0; win = 0;
        for (int k = 0; k < NR; k++)
          if (!found && rq[(ptr + k) % NR]) begin found = 1; win = (ptr + k) % NR; end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (rq[0]) win = 0;
`endif
        if (found) begin cur = win; beats = 0; end
      end else begin
        done = !rq[cur];
        if (ew) begin
          beats++;
          if (ls[cur] || beats == MB) done = 1;
        end
        if (done) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (cur != 0) ptr = (cur + 1) % NR;
`else
          ptr = (cur + 1) % NR;
`endif
          cur = -1;
        end
      end
    end
  endtask

  initial begin
    rs = 1'b0; rs_n = 1'b0; fl = 1'b0;
    rq = '1; ls = '0; req = '1; last = '0; full = 1'b0; data = '0;
    for (int i = 0; i < NR; i++) dat[i] = DW'(8'hA0 + i);
    repeat (3) cycle(0);
    rs = 1'b1;
    repeat (30) cycle(0);
    for (int c = 0; c < 500; c++) begin
      rs = !(c == 250 || c == 251);
      cycle(1);
    end
    rs = 1'b1;
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one FIFO write port between NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST beats.
- Drives the FIFO's wr strobe and write data, and honours the FIFO's full flag as backpressure.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4: number of producers, 2..8.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum beats per grant, >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-producer request/valid; bit i has data ready.
- last  in  NUM_REQ  per-producer end-of-burst marker, qualified by the accepted beat.
- data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  FIFO full flag.
- gnt  out  NUM_REQ  one-hot registered grant; all zero when idle.
- wr  out  1  FIFO write strobe.
- w_data  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, gnt=0, owner=0, rr_ptr=0, beat_cnt=0.
  - Outputs: wr=0, w_data=0, busy=0.
- FSM, two states:
  - IDLE -> BURST when |req. Winner is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. gnt[winner], owner and beat_cnt=0 are registered on that edge. Otherwise stay in IDLE.
  - BURST: combinational wr = req[owner] & ~full. w_data = data slice of owner (0 in IDLE). A beat is accepted when wr=1; beat_cnt increments on each accepted beat.
  - BURST -> IDLE on the edge after any of:
    (a) accepted beat with last[owner]=1;
    (b) accepted beat that makes beat_cnt == MAX_BURST;
    (c) req[owner]=0 (producer abandons; no write that cycle).
    On exit: gnt=0, busy=0, rr_ptr=(owner+1) mod NUM_REQ.
- Latency:
  - Request to first possible write: 1 cycle (grant registered).
  - One mandatory IDLE bubble between bursts.
- Backpressure: full=1 forces wr=0. beat_cnt and state hold; the burst does not time out.
- Simultaneous events:
  - Requests from non-owners during BURST are ignored until IDLE.
  - last and MAX_BURST reached on the same beat count as one end.
- beat_cnt width is $clog2(MAX_BURST+1); it never wraps.
- gnt is always one-hot or zero. Producers must hold data/last stable while req=1 and the beat is not accepted.
- Reset asserted mid-burst: immediate return to the reset values; the partial burst is dropped from arbitration state. FIFO contents are the FIFO's concern.

Optional Feature:
- Macro FIFO_WR_ARB_PRIO0_EN.
- Defined: producer 0 is fixed high priority. In IDLE, req[0]=1 wins regardless of rr_ptr, and rr_ptr is not updated after a producer-0 burst. All other producers keep round-robin.
- Undefined: pure round-robin as above.

Decomposition:
- Package fifo_wr_arb_pkg:
  - state enum {IDLE, BURST};
  - localparam MAX_NUM_REQ=8;
  - function rr_next(ptr, n) for modulo increment.
- One sub-module, rr_pick: purely combinational. Inputs req and rr_ptr; outputs one-hot win and binary win_idx.

Test Plan:
- Reset: hold reset low with req=4'b1111 -> gnt=0, wr=0, busy=0. After release, gnt=4'b0001 on the first edge.
- All four requesting continuously, last=0, MAX_BURST=4, full=0 -> grants rotate 0,1,2,3,0. Each burst writes exactly 4 words, with one idle cycle between bursts.
- Producer 2 sends 3 beats with last on beat 3 -> exactly 3 writes with data 0xA0..0xA2, then IDLE; next grant goes to 3 if requesting.
- full held high for 5 cycles mid-burst after beat 1 -> wr=0 for those 5 cycles, gnt unchanged. Beat 2 is written the cycle full drops; total beats still 4.
- Owner drops req after 2 beats -> exit to IDLE, no further writes, rr_ptr advances past the owner.
- With FIFO_WR_ARB_PRIO0_EN: producers 0 and 3 requesting, rr_ptr=3 -> producer 0 granted. Without the macro -> producer 3 granted.
